call_stack: RTL
===============

CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 Parameter DEPTH, default 8, number of 12-bit return-address entries (power of two, 2..64).
REQ-002 Parameter AW, default 12, address width; matches the program-counter address width.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port push  input  1  call: store push_addr as new top of stack.
REQ-006 Port pop  input  1  return: remove top of stack.
REQ-007 Port push_addr  input  AW  return address to store (caller PC + 1).
REQ-008 Port err_clr  input  1  synchronous clear of the sticky error flags.
REQ-009 Port stk0  output  AW  current top-of-stack value; this is the return target consumed by the PC stage.
REQ-010 Port count  output  log2(DEPTH)+1  number of valid entries.
REQ-011 Port empty  output  1  count == 0.
REQ-012 Port full  output  1  count == DEPTH.
REQ-013 Port ovf  output  1  sticky overflow flag.
REQ-014 Port unf  output  1  sticky underflow flag.

Function
REQ-015 Storage SHALL be a DEPTH x AW register array plus a stack pointer sp (0..DEPTH); count SHALL equal sp.
REQ-016 stk0 SHALL be combinational from registered state: entry[sp-1] when sp > 0, else all zeros; it has no added latency, so a value pushed in cycle N is visible on stk0 in cycle N+1.
REQ-017 push only, not full: entry[sp] <= push_addr, sp <= sp + 1.
REQ-018 pop only, not empty: sp <= sp - 1; the popped entry content need not be cleared.
REQ-019 push and pop in the same cycle, not empty: replace top. entry[sp-1] <= push_addr, sp unchanged, no flag change.
REQ-020 push and pop in the same cycle, empty: treat as push only. entry[0] <= push_addr, sp <= 1, unf unchanged.
REQ-021 push only when full: array and sp unchanged, and ovf <= 1.
REQ-022 pop only when empty: sp stays 0, stk0 stays 0, and unf <= 1.
REQ-023 Neither push nor pop: all state holds.
REQ-024 ovf and unf SHALL stay set until err_clr or reset.
REQ-025 err_clr clears both flags in the cycle it is sampled; if an error event occurs in the same cycle, the set wins.
REQ-026 err_clr SHALL NOT affect sp or the array.
REQ-027 full and empty SHALL be decoded combinationally from sp.
REQ-028 Entries SHALL be indexed directly by sp; there is no wrap-around and the oldest entry is never overwritten.

Reset
REQ-029 On rst_n low, asynchronously: sp = 0, ovf = 0, unf = 0, count = 0, empty = 1, full = 0, stk0 = 0.
REQ-030 Array contents need not be reset; they are unobservable while sp = 0.
REQ-031 Reset asserted mid-sequence discards all entries.
REQ-032 On the first clock edge after rst_n rises, push and pop are honoured normally.

Verification
REQ-033 Reset, then push 0x010, 0x020, 0x030 on consecutive cycles -> stk0 = 0x030, count = 3, empty = 0.
REQ-034 From REQ-033, pop three times -> stk0 sequence 0x020, 0x010, 0x000; empty = 1; unf = 0.
REQ-035 Push 8 distinct values (DEPTH = 8), then push 0xABC -> full = 1, ovf = 1, stk0 = 8th value, count = 8; then err_clr -> ovf = 0, stack unchanged.
REQ-036 With stack holding 0x100 and 0x200, assert push and pop together with push_addr = 0x3FF -> stk0 = 0x3FF, count = 2; a following pop gives stk0 = 0x100.
REQ-037 Pop when empty -> unf = 1, count = 0, stk0 = 0; err_clr and pop in the same cycle -> unf remains 1.
REQ-038 Push 0x555 twice, then drop rst_n between clock edges -> outputs immediately show count = 0, stk0 = 0, flags = 0; after release, push 0x777 -> stk0 = 0x777, count = 1.

Source files
------------

// File: rtl/call_stack.sv
// Hardware return-address stack for call/return instructions.
// The top entry is presented combinationally as the return target, and overflow/underflow are sticky error flags.
module call_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [AW-1:0]              push_addr,
    input  logic                       err_clr,
    output logic [AW-1:0]              stk0,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf,
    output logic                       unf
);

    localparam int IW  = $clog2(DEPTH);
    localparam int SPW = IW + 1;

    logic [AW-1:0]  entry_q [DEPTH];
    logic [SPW-1:0] sp_q, sp_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;

    logic           wr_en;
    logic [IW-1:0]  wr_idx;
    logic [SPW-1:0] sp_m1;
    logic [IW-1:0]  top_idx;

    assign empty   = (sp_q == '0);
    assign full    = (sp_q == SPW'(DEPTH));
    assign sp_m1   = sp_q - SPW'(1);
    assign top_idx = sp_m1[IW-1:0];

    always_comb begin
        sp_d   = sp_q;
        ovf_d  = ovf_q & ~err_clr;
        unf_d  = unf_q & ~err_clr;
        wr_en  = 1'b0;
        wr_idx = sp_q[IW-1:0];
        if (push && pop) begin
            // Simultaneous call and return replaces the top; on an empty stack it is a plain push.
            wr_en = 1'b1;
            if (empty) begin
                wr_idx = '0;
                sp_d   = SPW'(1);
            end else begin
                wr_idx = top_idx;
            end
        end else if (push) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                wr_en = 1'b1;
                sp_d  = sp_q + SPW'(1);
            end
        end else if (pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                sp_d = sp_m1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Storage is left unreset; entries at or above sp are never observed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            entry_q[wr_idx] <= push_addr;
        end
    end

    assign stk0  = empty ? '0 : entry_q[top_idx];
    assign count = sp_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule
